decoder_scan_seq: RTL
=====================

Name: decoder_scan_seq

Overview:
Parametrised, registered N-to-2^N one-hot decoder with a built-in index sequencer. It generalises the combinational 4-to-16 decoder to any input width. It adds three modes: direct decode, continuous auto-scan and one-shot sweep. Its intended use is driving LED banks and 7-segment anode/digit selects on the Artix-7 lab boards.

Parameters:
IN_W, 4, index width; output width OUT_W = 2^IN_W (derived, not overridable)
PRESCALE, 100000, clock cycles per scan/sweep step; legal range >= 1
LAST, 2^IN_W-1, highest index visited in SCAN/SWEEP; legal range 0..2^IN_W-1, elaboration error otherwise

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
en  in  1  global enable; 0 forces out to zero and pauses sequencing
mode  in  2  00 DIRECT, 01 SCAN, 10 SWEEP, 11 reserved (behaves as DIRECT)
sel  in  IN_W  index decoded in DIRECT mode
start  in  1  one-cycle pulse; launches a sweep in SWEEP mode
out  out  OUT_W  registered one-hot output (all zero when inactive)
idx  out  IN_W  current index driving out
busy  out  1  high while a sweep is running
done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset (rst_n=0, asynchronous): out=0, idx=0, busy=0, done=0, prescaler=0, state=S_DIRECT. Deassertion is synchronised externally.
- All outputs are registered. No combinational path from inputs to outputs.
- Registered decode: out <= en ? (1 << idx_next) : 0.
- Prescaler: counts 0..PRESCALE-1. tick=1 in the cycle where count==PRESCALE-1, then it wraps to 0. It runs only in S_SCAN or S_SWEEP_RUN with en=1. It is held when en=0 and cleared on every state change. With PRESCALE=1, tick is asserted every cycle.
- States: S_DIRECT, S_SCAN, S_SWEEP_IDLE, S_SWEEP_RUN. The state follows mode. Any mode change takes effect at the next edge, clears the prescaler, sets idx=0 and busy=0, and does not pulse done.
- S_DIRECT: idx <= sel, so out shows sel decoded one cycle after sel changes.
- S_SCAN: on tick, idx <= (idx==LAST) ? 0 : idx+1.
- S_SWEEP_IDLE: out=0 and busy=0. start=1 with en=1 moves to S_SWEEP_RUN, sets idx=0 and busy=1, and out=1 on the next edge. start with en=0 is ignored.
- S_SWEEP_RUN: on tick with idx<LAST, idx increments. On tick with idx==LAST: return to S_SWEEP_IDLE, busy=0, done=1 for exactly one cycle, out=0. start is ignored while busy.
- en=0 in any state: out=0 at the next edge. idx, state and prescaler are held. Sequencing resumes from the held values when en returns to 1.
- LAST=0: SCAN stays at idx 0. SWEEP completes on the first tick.
- Reset asserted mid-sweep: immediate return to the reset values, with no done pulse.

Optional Feature:
DECODER_ACTIVE_LOW_EN
- Defined: out is inverted at the register input, so the selected line is 0 and all others are 1. Reset and inactive value is all ones. This directly drives the common-anode displays on the lab boards.
- Undefined: active-high as above.
- idx, busy and done are unaffected either way.

Decomposition:
- Package decoder_pkg holds:
  - the mode encodings MODE_DIRECT/MODE_SCAN/MODE_SWEEP/MODE_RSVD;
  - the state enumeration;
  - a function onehot(idx) returning 1<<idx.
- One sub-module, tick_gen: parameter PRESCALE, inputs clk, rst_n, run, clr, output tick. It holds the prescaler logic.
- The decode register and the FSM stay in decoder_scan_seq.

Test Plan:
1. IN_W=4, DIRECT, en=1, sel=4'h4 -> out=16'h0010 one cycle later. sel=4'hF -> 16'h8000. en=0 -> 16'h0000 on the next edge.
2. SCAN, PRESCALE=3, LAST=15 -> idx advances every 3 cycles 0,1,..,15,0. out follows one-hot, with 48 cycles per full cycle.
3. SWEEP, PRESCALE=2, start pulse -> busy=1, out walks 16'h0001..16'h8000. done=1 for one cycle after idx 15's dwell, then busy=0 and out=0. A second start during busy has no effect.
4. SCAN at idx=5 with en=0 for 10 cycles -> out=0 and idx=5 held. After en=1, idx resumes at 5 with the prescaler count preserved.
5. Mode 10->00 mid-sweep at idx=7 -> busy=0 next edge, no done, idx=sel. rst_n low mid-sweep -> out=0, busy=0 asynchronously.
6. DECODER_ACTIVE_LOW_EN defined, DIRECT, sel=4'h0 -> out=16'hFFFE. Reset -> out=16'hFFFF.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder_scan_seq slice: mode encodings,
// sequencer states and a one-hot helper sized for the widest supported index.
package decoder_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Widest index the helper can decode; instances are checked against it.
    localparam int MAX_IN_W  = 10;
    localparam int MAX_OUT_W = 2 ** MAX_IN_W;

    typedef enum logic [1:0] {
        S_DIRECT,
        S_SCAN,
        S_SWEEP_IDLE,
        S_SWEEP_RUN
    } state_t;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] idx);
        return MAX_OUT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/decoder_scan_seq_tick_gen.sv
// Prescaler for the scan/sweep sequencer: produces a one-cycle tick every
// PRESCALE running cycles, holds while not running, clears on request.
module tick_gen #(
    parameter int PRESCALE = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] TOP = CW'(PRESCALE - 1);

    logic [CW-1:0] r_count;

    generate
        if (PRESCALE < 1) begin : g_badPrescale
            $error("tick_gen: PRESCALE must be >= 1");
        end
    endgenerate

    assign tick = run && (r_count == TOP);

    // Count 0..PRESCALE-1 while running; a clear always wins over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= tick ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/decoder_scan_seq.sv
// Registered N-to-2^N one-hot decoder with direct, auto-scan and one-shot
// sweep modes. Define DECODER_ACTIVE_LOW_EN to invert out (selected line low,
// idle value all ones) for common-anode displays.
module decoder_scan_seq
    import decoder_pkg::*;
#(
    parameter int IN_W     = 4,
    parameter int PRESCALE = 100000,
    parameter int LAST     = 2 ** IN_W - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [IN_W-1:0]      sel,
    input  logic                 start,
    output logic [2**IN_W-1:0]   out,
    output logic [IN_W-1:0]      idx,
    output logic                 busy,
    output logic                 done
);

    localparam int OUT_W = 2 ** IN_W;
    localparam logic [IN_W-1:0] LAST_IDX = IN_W'(LAST);

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] OUT_IDLE = '1;
`else
    localparam logic [OUT_W-1:0] OUT_IDLE = '0;
`endif

    generate
        if (IN_W < 1 || IN_W > MAX_IN_W) begin : g_badWidth
            $error("decoder_scan_seq: IN_W out of supported range");
        end
        if (LAST < 0 || LAST > OUT_W - 1) begin : g_badLast
            $error("decoder_scan_seq: LAST must be within 0..2^IN_W-1");
        end
    endgenerate

    state_t            r_state;
    state_t            w_stateNext;
    logic [IN_W-1:0]   r_idx;
    logic [IN_W-1:0]   w_idxNext;
    logic              r_busy;
    logic              w_busyNext;
    logic              r_done;
    logic              w_doneNext;
    logic [OUT_W-1:0]  r_out;
    logic [OUT_W-1:0]  w_outNext;
    logic              w_run;
    logic              w_clr;
    logic              w_tick;

    assign w_run = en && (r_state == S_SCAN || r_state == S_SWEEP_RUN);
    assign w_clr = en && (w_stateNext != r_state);

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tickGen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // Next state, index, busy/done and decoded output; a mode change overrides
    // any sequencing in the same cycle and everything holds while en is low.
    always_comb begin
        w_stateNext = r_state;
        w_idxNext   = r_idx;
        w_busyNext  = r_busy;
        w_doneNext  = 1'b0;
        w_outNext   = OUT_IDLE;
        if (en) begin
            case (mode)
                MODE_SCAN: begin
                    if (r_state != S_SCAN) begin
                        w_stateNext = S_SCAN;
                    end
                end
                MODE_SWEEP: begin
                    if (r_state != S_SWEEP_IDLE && r_state != S_SWEEP_RUN) begin
                        w_stateNext = S_SWEEP_IDLE;
                    end
                end
                MODE_DIRECT, MODE_RSVD: begin
                    if (r_state != S_DIRECT) begin
                        w_stateNext = S_DIRECT;
                    end
                end
                default: begin
                    w_stateNext = r_state;
                end
            endcase

            if (w_stateNext != r_state) begin
                w_idxNext  = '0;
                w_busyNext = 1'b0;
            end else begin
                case (r_state)
                    S_DIRECT: begin
                        w_idxNext = sel;
                    end
                    S_SCAN: begin
                        if (w_tick) begin
                            w_idxNext = (r_idx == LAST_IDX) ? '0 : r_idx + IN_W'(1);
                        end
                    end
                    S_SWEEP_IDLE: begin
                        if (start) begin
                            w_stateNext = S_SWEEP_RUN;
                            w_idxNext   = '0;
                            w_busyNext  = 1'b1;
                        end
                    end
                    S_SWEEP_RUN: begin
                        if (w_tick) begin
                            if (r_idx == LAST_IDX) begin
                                w_stateNext = S_SWEEP_IDLE;
                                w_busyNext  = 1'b0;
                                w_doneNext  = 1'b1;
                            end else begin
                                w_idxNext = r_idx + IN_W'(1);
                            end
                        end
                    end
                    default: begin
                        w_stateNext = S_DIRECT;
                    end
                endcase
            end

            if (w_stateNext != S_SWEEP_IDLE) begin
`ifdef DECODER_ACTIVE_LOW_EN
                w_outNext = ~OUT_W'(onehot(MAX_IN_W'(w_idxNext)));
`else
                w_outNext = OUT_W'(onehot(MAX_IN_W'(w_idxNext)));
`endif
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_DIRECT;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= OUT_IDLE;
        end else begin
            r_state <= w_stateNext;
            r_idx   <= w_idxNext;
            r_busy  <= w_busyNext;
            r_done  <= w_doneNext;
            r_out   <= w_outNext;
        end
    end

    assign out  = r_out;
    assign idx  = r_idx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
